// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative MULT/DIV engine.
package mult_div_pkg;

  // Engine sequencing states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Operation latched at start
  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  // R-type funct codes that steer the control FSM into/out of this unit
  localparam logic [5:0] MULT = 6'b011000;
  localparam logic [5:0] DIV  = 6'b011010;
  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MFLO = 6'b010010;

endpackage

// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control FSM and the MULT/DIV engine.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  // Control side: issues strobes and operands, consumes results
  modport master (
    output start_mult, start_div, a, b,
    input  hi, lo, busy, done, div_zero
  );

  // Engine side
  modport slave (
    input  start_mult, start_div, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/twos_negate.sv
// Combinational two's-complement negation; the most negative value maps to itself.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = ~i_x + WIDTH'(1);
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV engine with architectural HI/LO registers.
// Magnitudes are processed unsigned over WIDTH iterations; signs are restored at the end.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  mult_div_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  op_t                r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [CW-1:0]      r_cnt;
  logic               r_sign_res;
  logic               r_sign_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;

  logic [WIDTH-1:0]   w_neg_a;
  logic [WIDTH-1:0]   w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_start;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_quot_neg;
  logic [WIDTH-1:0]   w_rem_neg;
  logic               w_last;

  // Operand magnitudes; -2^(W-1) stays as its own bit pattern, read as unsigned 2^(W-1)
  twos_negate #(.WIDTH(WIDTH)) u_neg_a (.i_x(bus.a), .o_y(w_neg_a));
  twos_negate #(.WIDTH(WIDTH)) u_neg_b (.i_x(bus.b), .o_y(w_neg_b));

  // Sign fixups applied once the unsigned iteration finishes
  twos_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.i_x(r_acc), .o_y(w_prod_neg));
  twos_negate #(.WIDTH(WIDTH)) u_neg_quot (.i_x(r_acc[WIDTH-1:0]), .o_y(w_quot_neg));
  twos_negate #(.WIDTH(WIDTH)) u_neg_rem (.i_x(r_acc[2*WIDTH-1:WIDTH]), .o_y(w_rem_neg));

  assign w_abs_a = bus.a[WIDTH-1] ? w_neg_a : bus.a;
  assign w_abs_b = bus.b[WIDTH-1] ? w_neg_b : bus.b;
  assign w_start = bus.start_mult | bus.start_div;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  // Shift-add step: low half holds the remaining multiplier bits, consumed LSB first;
  // the extra carry bit of the add shifts into the top of the accumulator.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring step: shift {rem,quot} left by one, trial-subtract the divisor, keep or restore
  assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_trial - {1'b0, r_opb};
  assign w_div_next = w_diff[WIDTH] ? {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  // Sequencing FSM with all outputs registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= OP_MULT;
      r_acc      <= '0;
      r_opb      <= '0;
      r_cnt      <= '0;
      r_sign_res <= 1'b0;
      r_sign_rem <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op       <= bus.start_mult ? OP_MULT : OP_DIV;
            r_acc      <= {{WIDTH{1'b0}}, w_abs_a};
            r_opb      <= w_abs_b;
            r_cnt      <= '0;
            r_sign_res <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_sign_rem <= bus.a[WIDTH-1];
            r_busy     <= 1'b1;
            r_div_zero <= 1'b0;
            if (!bus.start_mult && (bus.b == '0)) begin
              // Divide by zero skips the datapath; HI/LO keep their prior contents
              r_div_zero <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= (r_op == OP_MULT) ? w_mul_next : w_div_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_SIGN;
          end
        end
        S_SIGN: begin
          if (r_op == OP_MULT) begin
            {r_hi, r_lo} <= r_sign_res ? w_prod_neg : r_acc;
          end else begin
            r_lo <= r_sign_res ? w_quot_neg : r_acc[WIDTH-1:0];
            r_hi <= r_sign_rem ? w_rem_neg : r_acc[2*WIDTH-1:WIDTH];
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes reference results, a monitor checks on done.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  longint cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    longint      lat;
    longint      start;
  } exp_t;

  exp_t sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse retires the oldest expected result
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("done: hi=%h lo=%h dz=%0d latency=%0d", bus.hi, bus.lo, bus.div_zero, cyc + 1 - e.start);
        chk("hi", {32'd0, bus.hi}, {32'd0, e.hi});
        chk("lo", {32'd0, bus.lo}, {32'd0, e.lo});
        chk("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
        chk("latency", 64'(cyc + 1 - e.start), 64'(e.lat));
        chk("busy_at_done", {63'd0, bus.busy}, 64'd1);
      end
      done_seen++;
    end
  end

  // Reference model from signed-arithmetic rules; pushes the expectation and drives one start
  task automatic drive_start(input bit is_mult, input bit both, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint p, q, r;
    if (is_mult || both) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e.hi = p[63:32]; e.lo = p[31:0]; e.dz = 1'b0; e.lat = 34;
    end else if (b == 32'd0) begin
      e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1; e.lat = 1;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      e.hi = r[31:0]; e.lo = q[31:0]; e.dz = 1'b0; e.lat = 34;
    end
    m_hi = e.hi;
    m_lo = e.lo;
    @(negedge clk); #1;
    bus.a = a;
    bus.b = b;
    bus.start_mult = is_mult | both;
    bus.start_div  = ~is_mult | both;
    e.start = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk); #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int t = 0;
    while (done_seen == n0 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (done_seen == n0) chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input bit is_mult, input bit both, input logic [31:0] a, input logic [31:0] b);
    int n0 = done_seen;
    drive_start(is_mult, both, a, b);
    wait_done(n0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prev_hi, prev_lo, ra, rb;
    int n0, k;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'd0, bus.hi}, 64'd0);
    chk("reset_lo", {32'd0, bus.lo}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_dz", {63'd0, bus.div_zero}, 64'd0);
    rst_n = 1'b1;

    // Directed corner cases
    run_op(1, 0, 32'd7, 32'hFFFF_FFFD);
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000);
    run_op(0, 0, 32'hFFFF_FFF9, 32'd2);
    run_op(0, 0, 32'd7, 32'hFFFF_FFFE);
    run_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(0, 0, 32'd5, 32'd0);
    @(negedge clk); #1;
    chk("dz_held", {63'd0, bus.div_zero}, 64'd1);
    chk("idle_busy", {63'd0, bus.busy}, 64'd0);
    run_op(1, 0, 32'd6, 32'd9);
    run_op(0, 1, 32'hFFFF_FFFB, 32'd9);

    // A start_div (with b=0) during CALC must be ignored; outputs stay frozen while busy
    prev_hi = m_hi;
    prev_lo = m_lo;
    n0 = done_seen;
    drive_start(1, 0, 32'd1234567, 32'hFFFF_FFA7);
    repeat (5) begin @(negedge clk); #1; end
    bus.start_div = 1'b1;
    bus.b = 32'd0;
    @(negedge clk); #1;
    bus.start_div = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    chk("busy_mid_calc", {63'd0, bus.busy}, 64'd1);
    chk("hi_stable", {32'd0, bus.hi}, {32'd0, prev_hi});
    chk("lo_stable", {32'd0, bus.lo}, {32'd0, prev_lo});
    wait_done(n0);

    // Asynchronous reset in the middle of CALC
    run_op(1, 0, 32'hFFFF_FFFF, 32'd5);
    drive_start(1, 0, 32'h0001_2345, 32'h0000_0777);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", {32'd0, bus.hi}, 64'd0);
    chk("arst_lo", {32'd0, bus.lo}, 64'd0);
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_done", {63'd0, bus.done}, 64'd0);
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 0, 32'd3, 32'd4);

    // Randomized mix of MULT/DIV including divide-by-zero and extreme operands
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 3);
      ra = pick();
      rb = pick();
      if (k == 3 && $urandom_range(0, 3) == 0) rb = 32'd0;
      run_op(k < 2, 0, ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
